// File: rtl/mdu_pkg.sv
// mdu_pkg: MDU operation/MTHILO encodings and operand width shared by MDU, controller and issue queue
package mdu_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [3:0] {
    OP_MULTU = 4'b0000,
    OP_MULT  = 4'b0001,
    OP_DIVU  = 4'b0010,
    OP_DIV   = 4'b0011,
    OP_MADDU = 4'b0100,
    OP_MADD  = 4'b0101,
    OP_MSUBU = 4'b0110,
    OP_MSUB  = 4'b0111,
    OP_NONE  = 4'b1111
  } mdu_op_e;
  typedef enum logic [1:0] {
    MTHILO_NONE = 2'b00,
    MTHILO_LO   = 2'b01,
    MTHILO_HI   = 2'b11
  } mthilo_e;
  // A request carrying neither an arithmetic op nor a HI/LO move does nothing
  function automatic logic is_null(input logic [3:0] op, input logic [1:0] mthilo);
    return op[3] && (mthilo == MTHILO_NONE);
  endfunction
endpackage

// File: rtl/mdu_issue_queue_sync_fifo.sv
// sync_fifo: circular storage with wrapping pointers and registered occupancy
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push && !reset) r_mem[r_wr] <= i_data;
  end
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/mdu_issue_queue.sv
// mdu_issue_queue: in-order buffer between EX and the MDU; drops null requests, issues head when MDU idle
module mdu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WORD_W = mdu_pkg::WORD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [1:0]               in_mthilo,
  input  logic [WORD_W-1:0]        in_a,
  input  logic [WORD_W-1:0]        in_b,
  input  logic                     mdu_busy,
  output logic                     out_valid,
  output logic [3:0]               out_op,
  output logic [1:0]               out_mthilo,
  output logic [WORD_W-1:0]        out_a,
  output logic [WORD_W-1:0]        out_b,
  output logic                     hilo_pending,
  output logic [$clog2(DEPTH):0]   count
);
  import mdu_pkg::*;
  localparam int EW = 6 + 2 * WORD_W;
  logic [EW-1:0] w_head;
  logic          w_full, w_empty, w_push;
  // Full queue never accepts, even if the head leaves on the same edge
  assign in_ready     = ~w_full;
  assign w_push       = in_valid & in_ready & ~is_null(in_op, in_mthilo);
  assign out_valid    = ~w_empty & ~mdu_busy;
  assign hilo_pending = ~w_empty | mdu_busy;
  assign out_op       = out_valid ? w_head[EW-1 -: 4] : OP_NONE;
  assign out_mthilo   = out_valid ? w_head[EW-5 -: 2] : MTHILO_NONE;
  assign out_a        = out_valid ? w_head[2*WORD_W-1 -: WORD_W] : '0;
  assign out_b        = out_valid ? w_head[WORD_W-1:0] : '0;
  sync_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_pop(out_valid),
    .i_data({in_op, in_mthilo, in_a, in_b}),
    .o_data(w_head),
    .o_count(count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
endmodule

// File: tb/tb_mdu_issue_queue.sv
// tb_mdu_issue_queue: randomized + directed scoreboard bench with a behavioural MDU driven by issued ops
module tb_mdu_issue_queue;
  import mdu_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, mdu_busy, force_busy = 0;
  logic [3:0] in_op = OP_NONE;
  logic [1:0] in_mthilo = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic out_valid, hilo_pending;
  logic [3:0] out_op;
  logic [1:0] out_mthilo;
  logic [31:0] out_a, out_b, hi, lo;
  logic [2:0] count;
  logic [2:0] mdu_cnt;
  int n_cmp = 0, n_err = 0;
  logic [69:0] sb [$];

  mdu_issue_queue #(.DEPTH(DEPTH), .WORD_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_mthilo(in_mthilo), .in_a(in_a), .in_b(in_b),
    .mdu_busy(mdu_busy), .out_valid(out_valid), .out_op(out_op),
    .out_mthilo(out_mthilo), .out_a(out_a), .out_b(out_b),
    .hilo_pending(hilo_pending), .count(count)
  );

  always #5 clk = ~clk;
  assign mdu_busy = force_busy | (mdu_cnt != 0);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a, b, h, l);
    longint sa = $signed(a);
    longint sb2 = $signed(b);
    logic [63:0] acc = {h, l};
    logic [63:0] pu = {32'b0, a} * {32'b0, b};
    logic [63:0] ps = sa * sb2;
    case (op)
      OP_MULTU: return pu;
      OP_MULT:  return ps;
      OP_DIVU:  return (b == 0) ? acc : {a % b, a / b};
      OP_DIV:   return (b == 0) ? acc : {32'(sa % sb2), 32'(sa / sb2)};
      OP_MADDU: return acc + pu;
      OP_MADD:  return acc + ps;
      OP_MSUBU: return acc - pu;
      OP_MSUB:  return acc - ps;
      default:  return acc;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mdu_cnt <= 0;
      hi <= 0;
      lo <= 0;
    end else begin
      if (mdu_cnt != 0) mdu_cnt <= mdu_cnt - 1;
      if (out_valid) begin
        if (out_mthilo == MTHILO_HI) hi <= out_a;
        else if (out_mthilo == MTHILO_LO) lo <= out_a;
        else if (!out_op[3]) begin
          mdu_cnt <= 3;
          {hi, lo} <= mdu_calc(out_op, out_a, out_b, hi, lo);
        end
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    logic ev;
    logic [69:0] e;
    sz = sb.size();
    ev = (sz != 0) && !mdu_busy;
    chk("count", count, sz);
    chk("in_ready", in_ready, sz < DEPTH);
    chk("hilo_pending", hilo_pending, (sz != 0) || mdu_busy);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      e = sb.pop_front();
      chk("out_op", out_op, e[69:66]);
      chk("out_mthilo", out_mthilo, e[65:64]);
      chk("out_a", out_a, e[63:32]);
      chk("out_b", out_b, e[31:0]);
    end else begin
      chk("idle_op", out_op, OP_NONE);
      chk("idle_ab", {out_mthilo, out_a, out_b}, 0);
    end
    if (reset) sb.delete();
    else if (in_valid && sz < DEPTH && !(in_op[3] && in_mthilo == 2'b00))
      sb.push_back({in_op, in_mthilo, in_a, in_b});
  end

  task automatic send(input logic [3:0] op, input logic [1:0] mt, input logic [31:0] a, b);
    int t;
    in_valid = 1; in_op = op; in_mthilo = mt; in_a = a; in_b = b;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (t == 100) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (count == 0 && !mdu_busy) break;
    end
    if (t == 200) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(OP_MULT, MTHILO_NONE, 32'hFFFFFFFE, 32'd3);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_op", out_op, OP_MULT);
    drain();
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    force_busy = 1;
    for (int i = 0; i < 4; i++) send(OP_MULTU, MTHILO_NONE, i + 1, 2);
    @(negedge clk);
    chk("bp_count", count, 4);
    chk("bp_ready", in_ready, 0);
    fork
      send(OP_DIVU, MTHILO_NONE, 100, 7);
      begin repeat (4) @(posedge clk); #1 force_busy = 0; end
    join
    drain();
    chk("bp_div_hi", hi, 2);
    chk("bp_div_lo", lo, 14);
    force_busy = 1;
    send(OP_NONE, MTHILO_HI, 32'h11, 0);
    send(OP_NONE, MTHILO_LO, 32'h22, 0);
    send(OP_MADDU, MTHILO_NONE, 2, 3);
    force_busy = 0;
    drain();
    chk("ord_hi", hi, 32'h11);
    chk("ord_lo", lo, 32'h28);
    force_busy = 1;
    send(OP_NONE, MTHILO_HI, 1, 0);
    send(OP_NONE, MTHILO_HI, 2, 0);
    force_busy = 0;
    send(OP_NONE, MTHILO_LO, 3, 0);
    @(negedge clk);
    chk("pushpop_count", count, 2);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send(OP_NONE, (i % 2) ? MTHILO_LO : MTHILO_HI, $urandom, $urandom);
    drain();
    send(OP_NONE, MTHILO_NONE, 5, 5);
    @(negedge clk);
    chk("null_count", count, 0);
    @(posedge clk); #1;
    force_busy = 1;
    for (int i = 0; i < 3; i++) send(OP_NONE, MTHILO_LO, i, 0);
    @(negedge clk);
    chk("pre_rst_count", count, 3);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    force_busy = 0;
    @(negedge clk);
    chk("post_rst_count", count, 0);
    chk("post_rst_op", out_op, OP_NONE);
    chk("post_rst_pending", hilo_pending, mdu_busy);
    @(posedge clk); #1;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      in_valid = $urandom_range(0, 2) != 0;
      in_op = (r < 4) ? 4'($urandom_range(0, 7)) : (r == 9) ? 4'($urandom_range(8, 15)) : OP_NONE;
      in_mthilo = (r < 4 || r >= 7) ? MTHILO_NONE : (r == 5) ? MTHILO_LO : MTHILO_HI;
      in_a = $urandom;
      in_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      force_busy = $urandom_range(0, 7) == 0;
      reset = $urandom_range(0, 199) == 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    reset = 0;
    force_busy = 0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
